// File: rtl/nvdla_csb_sequencer_pkg.sv
// Shared types and constants for the NVDLA CSB command sequencer.
package nvdla_csb_sequencer_pkg;

  localparam int NVDLA_CSB_ADDR_W = 16;
  localparam int NVDLA_CSB_DATA_W = 32;
  localparam int NVDLA_CSB_TO_W   = 10;

  localparam logic [NVDLA_CSB_DATA_W-1:0] NVDLA_CSB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [NVDLA_CSB_ADDR_W-1:0] addr;
    logic [NVDLA_CSB_DATA_W-1:0] wdat;
    logic                        write;
    logic                        nposted;
  } csb_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RSP      = 2'd3
  } csb_seq_state_e;

  // Reads and non-posted writes leave a transaction outstanding on the CSB.
  function automatic logic csb_expects_rsp(input csb_cmd_t c);
    return !c.write || c.nposted;
  endfunction

endpackage

// File: rtl/nvdla_csb_sequencer_cmd_fifo.sv
// Command FIFO for the CSB sequencer: head plus the entry behind it are visible so
// back-to-back posted writes can be chained without a bubble.
module nvdla_csb_cmd_fifo
  import nvdla_csb_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  csb_cmd_t                     data_i,
  output csb_cmd_t                     head_o,
  output csb_cmd_t                     next_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  csb_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // Flush beats both push and pop issued in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  assign rd_nxt = rd_q + PTR_ONE;
  assign head_o = mem_q[rd_q];
  assign next_o = mem_q[rd_nxt];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/nvdla_csb_sequencer.sv
// Sequences queued HWPE register commands onto the NVDLA csb2nvdla/nvdla2csb port.
// Build option NVDLA_CSB_TIMEOUT_EN adds a response timeout that returns an error response.
module nvdla_csb_sequencer
  import nvdla_csb_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  csb_cmd_t                    cmd_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [NVDLA_CSB_DATA_W-1:0] rsp_data_o,
  output logic                        rsp_err_o,
  output logic                        csb2nvdla_valid_o,
  input  logic                        csb2nvdla_ready_i,
  output logic [NVDLA_CSB_ADDR_W-1:0] csb2nvdla_addr_o,
  output logic [NVDLA_CSB_DATA_W-1:0] csb2nvdla_wdat_o,
  output logic                        csb2nvdla_write_o,
  output logic                        csb2nvdla_nposted_o,
  input  logic                        nvdla2csb_valid_i,
  input  logic [NVDLA_CSB_DATA_W-1:0] nvdla2csb_data_i,
  input  logic                        nvdla2csb_wr_complete_i,
  output logic                        busy_o,
  output logic                        spurious_o,
  output csb_seq_state_e              dbg_state_o
);

  // Handshakes (cmd, csb2nvdla, rsp): a transfer happens on a cycle where valid and ready are
  // both high; once raised, valid and its payload stay unchanged until that transfer.

  localparam int CNT_W = $clog2(CMD_DEPTH + 1);

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("nvdla_csb_sequencer: CMD_DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << NVDLA_CSB_TO_W)) begin : g_bad_timeout
    $error("nvdla_csb_sequencer: TIMEOUT_CYCLES must fit the timeout counter");
  end

  csb_seq_state_e              state_q, state_d;
  csb_cmd_t                    cmd_q, cmd_d;
  logic                        own_q, own_d;
  logic                        supp_q, supp_d;
  logic [NVDLA_CSB_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                        spur_q, spur_d;

  csb_cmd_t                    fifo_head;
  csb_cmd_t                    fifo_next;
  logic [CNT_W-1:0]            fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;

  logic                        push_acc;
  logic                        avail_now;
  csb_cmd_t                    cand_now;
  logic                        rem_avail;
  csb_cmd_t                    rem_cand;
  logic                        rd_rsp_ok;
  logic                        wr_rsp_ok;
  logic                        rsp_hit;
  logic                        spur_ev;

`ifdef NVDLA_CSB_TIMEOUT_EN
  localparam logic [NVDLA_CSB_TO_W-1:0] TO_LAST = NVDLA_CSB_TO_W'(TIMEOUT_CYCLES - 1);
  logic [NVDLA_CSB_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic                      rsp_err_q, rsp_err_d;
`endif

  nvdla_csb_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .pop_i   (fifo_pop),
    .flush_i (clear_i),
    .data_i  (cmd_i),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign push_acc  = cmd_valid_i && !fifo_full && !clear_i;
  // A command arriving into an empty FIFO is forwarded straight into the request register.
  assign avail_now = !fifo_empty || push_acc;
  assign cand_now  = fifo_empty ? cmd_i : fifo_head;

  // Successor after the in-flight head pops; own_q says the head is still a FIFO entry.
  assign rem_avail = own_q ? ((fifo_count >= CNT_W'(2)) || ((fifo_count == CNT_W'(1)) && push_acc))
                           : avail_now;
  assign rem_cand  = own_q ? ((fifo_count >= CNT_W'(2)) ? fifo_next : cmd_i) : cand_now;

  assign rd_rsp_ok = (state_q == WAIT_RSP) && !cmd_q.write;
  assign wr_rsp_ok = (state_q == WAIT_RSP) && cmd_q.write;
  assign rsp_hit   = (rd_rsp_ok && nvdla2csb_valid_i) || (wr_rsp_ok && nvdla2csb_wr_complete_i);
  assign spur_ev   = (nvdla2csb_valid_i && !rd_rsp_ok) || (nvdla2csb_wr_complete_i && !wr_rsp_ok);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    own_d      = own_q;
    supp_d     = supp_q;
    rsp_data_d = rsp_data_q;
    spur_d     = (spur_q && !clear_i) || spur_ev;
    fifo_pop   = 1'b0;
`ifdef NVDLA_CSB_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!clear_i && avail_now) begin
          state_d = ISSUE;
          cmd_d   = cand_now;
          own_d   = 1'b1;
          supp_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (clear_i) begin
          own_d  = 1'b0;
          supp_d = 1'b1;
        end
        if (csb2nvdla_ready_i) begin
          fifo_pop = own_q;
          own_d    = 1'b0;
          if (csb_expects_rsp(cmd_q)) begin
            state_d = WAIT_RSP;
`ifdef NVDLA_CSB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else if (!clear_i && rem_avail) begin
            cmd_d  = rem_cand;
            own_d  = 1'b1;
            supp_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        if (clear_i) supp_d = 1'b1;
        if (rsp_hit) begin
          rsp_data_d = cmd_q.write ? '0 : nvdla2csb_data_i;
          state_d    = (supp_q || clear_i) ? IDLE : RSP;
`ifdef NVDLA_CSB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d = NVDLA_CSB_TIMEOUT_DATA;
          rsp_err_d  = 1'b1;
          state_d    = (supp_q || clear_i) ? IDLE : RSP;
        end else begin
          to_cnt_d = to_cnt_q + NVDLA_CSB_TO_W'(1);
`endif
        end
      end
      RSP: begin
        if (clear_i) begin
          state_d = IDLE;
        end else if (rsp_ready_i) begin
          if (avail_now) begin
            state_d = ISSUE;
            cmd_d   = cand_now;
            own_d   = 1'b1;
            supp_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      own_q      <= 1'b0;
      supp_q     <= 1'b0;
      rsp_data_q <= '0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      own_q      <= own_d;
      supp_q     <= supp_d;
      rsp_data_q <= rsp_data_d;
      spur_q     <= spur_d;
    end
  end

`ifdef NVDLA_CSB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign cmd_ready_o         = !fifo_full;
  assign rsp_valid_o         = (state_q == RSP);
  assign rsp_data_o          = rsp_data_q;
  assign csb2nvdla_valid_o   = (state_q == ISSUE);
  assign csb2nvdla_addr_o    = cmd_q.addr;
  assign csb2nvdla_wdat_o    = cmd_q.wdat;
  assign csb2nvdla_write_o   = cmd_q.write;
  assign csb2nvdla_nposted_o = cmd_q.nposted;
  assign busy_o              = (state_q != IDLE) || !fifo_empty;
  assign spurious_o          = spur_q;
  assign dbg_state_o         = state_q;

endmodule
